// File: rtl/enigma_rotor_stage_if.sv
// Bundle of configuration, stepping and translation signals between a rotor
// stack controller (master) and one enigma_rotor_stage (slave).
interface enigma_rotor_stage_if #(
  parameter int unsigned W = 5
);
  logic         cfg_we;
  logic [W-1:0] cfg_addr;
  logic [W-1:0] cfg_data;
  logic         pos_we;
  logic [W-1:0] pos_data;
  logic [W-1:0] ring;
  logic         step_in;
  logic         in_valid;
  logic         dir;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         carry_out;
  logic [W-1:0] position;

  modport master (
    output cfg_we, cfg_addr, cfg_data, pos_we, pos_data, ring,
           step_in, in_valid, dir, in_data,
    input  out_valid, out_data, carry_out, position
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, pos_we, pos_data, ring,
           step_in, in_valid, dir, in_data,
    output out_valid, out_data, carry_out, position
  );
endinterface

// File: rtl/enigma_rotor_stage.sv
// Clocked Enigma rotor stage: loadable wiring table, stepping position with
// notch carry, ring setting, and a one-cycle registered translation path.
// Optional macro ROTOR_REV_PATH_EN builds the inverse table and honours dir;
// without it every request takes the forward path.
module enigma_rotor_stage #(
  parameter int unsigned N     = 26,
  parameter int unsigned W     = 5,
  parameter int unsigned NOTCH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  enigma_rotor_stage_if.slave bus
);
  typedef logic [W-1:0] sym_t;
  typedef logic [W:0]   ext_t;

  localparam ext_t N_EXT     = ext_t'(N);
  localparam sym_t NOTCH_SYM = sym_t'(NOTCH);
  localparam sym_t LAST_SYM  = sym_t'(N - 1);

  // (a + b) mod N for a, b < N, at W+1 bits.
  function automatic sym_t add_mod(input sym_t a, input sym_t b);
    ext_t sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= N_EXT) sum = sum - N_EXT;
    return sum[W-1:0];
  endfunction

  // (a - b) mod N for a, b < N, at W+1 bits.
  function automatic sym_t sub_mod(input sym_t a, input sym_t b);
    ext_t diff;
    diff = {1'b0, a} - {1'b0, b};
    if (a < b) diff = diff + N_EXT;
    return diff[W-1:0];
  endfunction

  // Fold an out-of-range setting back into 0..N-1 with a single subtract.
  function automatic sym_t reduce(input sym_t x);
    ext_t v;
    v = {1'b0, x};
    if (v >= N_EXT) v = v - N_EXT;
    return v[W-1:0];
  endfunction

  sym_t fwd [N];
`ifdef ROTOR_REV_PATH_EN
  sym_t inv [N];
`else
  logic unused_dir;
  assign unused_dir = bus.dir;
`endif

  sym_t position_q;
  logic out_valid_q;
  sym_t out_data_q;
  logic carry_q;

  sym_t ring_eff;
  sym_t pos_load;
  logic in_range;
  logic cfg_ok;
  sym_t s_idx;
  sym_t table_out;
  sym_t xlat;

  // Datapath: ring/position offsets into the table and back out again.
  always_comb begin
    // NOTE: every signal in this block gets a default first so no latch is inferred.
    ring_eff  = reduce(bus.ring);
    pos_load  = reduce(bus.pos_data);
    in_range  = ({1'b0, bus.in_data} < N_EXT);
    cfg_ok    = bus.cfg_we && ({1'b0, bus.cfg_addr} < N_EXT)
                           && ({1'b0, bus.cfg_data} < N_EXT);
    s_idx     = sub_mod(add_mod(in_range ? bus.in_data : '0, position_q), ring_eff);
    table_out = fwd[s_idx];
`ifdef ROTOR_REV_PATH_EN
    if (bus.dir) table_out = inv[s_idx];
`endif
    xlat      = in_range ? add_mod(sub_mod(table_out, position_q), ring_eff)
                         : bus.in_data;
  end

  // Wiring table(s): identity after reset, paired writes keep inv consistent.
  always_ff @(posedge clk) begin
    // NOTE: the tables must come out of reset as identity, so they are real
    // flops with a reset loop rather than an un-reset RAM.
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) begin
        fwd[i] <= sym_t'(i);
`ifdef ROTOR_REV_PATH_EN
        inv[i] <= sym_t'(i);
`endif
      end
    end else if (cfg_ok) begin
      // NOTE: non-blocking assignments for all sequential state, so reads in
      // this cycle see pre-edge values and ordering between blocks is irrelevant.
      fwd[bus.cfg_addr] <= bus.cfg_data;
`ifdef ROTOR_REV_PATH_EN
      inv[bus.cfg_data] <= bus.cfg_addr;
`endif
    end
  end

  // Position register with load priority over stepping, plus notch carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      position_q <= '0;
      carry_q    <= 1'b0;
    end else if (bus.pos_we) begin
      position_q <= pos_load;
      carry_q    <= 1'b0;
    end else if (bus.step_in) begin
      position_q <= (position_q == LAST_SYM) ? '0 : position_q + sym_t'(1);
      carry_q    <= (position_q == NOTCH_SYM);
    end else begin
      carry_q    <= 1'b0;
    end
  end

  // Registered translation result, one cycle after the request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) out_data_q <= xlat;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.carry_out = carry_q;
  assign bus.position  = position_q;
endmodule

// File: tb/tb_enigma_rotor_stage.sv
// Directed bench for enigma_rotor_stage: expected translations go into a
// scoreboard queue; a negedge monitor pops and compares on every out_valid.
module tb_enigma_rotor_stage;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [W-1:0] exp_q[$];

  enigma_rotor_stage_if #(.W(W)) bus ();

  enigma_rotor_stage #(.N(26), .W(W), .NOTCH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every presented result must match the oldest expected one.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got data %0d, expected no output", bus.out_data);
      end else begin
        automatic logic [W-1:0] e = exp_q.pop_front();
        check("out_data", int'(bus.out_data), int'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input int d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = W'(a);
    bus.cfg_data = W'(d);
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic load_pos(input int p);
    bus.pos_we   = 1'b1;
    bus.pos_data = W'(p);
    tick();
    bus.pos_we   = 1'b0;
  endtask

  task automatic send(input int d, input logic dr, input int expected);
    bus.in_valid = 1'b1;
    bus.in_data  = W'(d);
    bus.dir      = dr;
    exp_q.push_back(W'(expected));
    tick();
    bus.in_valid = 1'b0;
    bus.dir      = 1'b0;
  endtask

  int wiring_i [26] = '{4,10,12,5,11,6,3,16,21,25,13,19,14,22,24,7,23,20,18,15,0,8,1,17,2,9};

  initial begin
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_data = 0;
    bus.pos_we = 0; bus.pos_data = 0; bus.ring = 0;
    bus.step_in = 0; bus.in_valid = 0; bus.dir = 0; bus.in_data = 0;
    rst_n = 1'b0;
    tick();
    tick();
    check("reset_position", int'(bus.position), 0);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_data", int'(bus.out_data), 0);
    check("reset_carry", int'(bus.carry_out), 0);
    rst_n = 1'b1;

    // Identity table after reset, then idle cycles must stay silent.
    send(3, 1'b0, 3);
    tick();
    tick();
    check("idle_out_valid", int'(bus.out_valid), 0);

    // Load wiring I; out-of-range writes must be ignored.
    for (int i = 0; i < 26; i++) cfg_write(i, wiring_i[i]);
    cfg_write(30, 0);
    cfg_write(0, 30);
    load_pos(0);
    send(0, 1'b0, 4);
    send(25, 1'b0, 9);
`ifdef ROTOR_REV_PATH_EN
    send(4, 1'b1, 0);
    send(9, 1'b1, 25);
`else
    send(4, 1'b1, 11);
    send(9, 1'b1, 25);
`endif

    // Position and ring offsets.
    load_pos(1);
    send(0, 1'b0, 9);
    load_pos(0);
    bus.ring = 5'd1;
    send(0, 1'b0, 10);
    bus.ring = 5'd27;
    send(0, 1'b0, 10);
    bus.ring = 5'd0;
    send(30, 1'b0, 30);

    // Stepping and notch carry.
    load_pos(16);
    bus.step_in = 1'b1;
    tick();
    bus.step_in = 1'b0;
    check("step_from_notch_pos", int'(bus.position), 17);
    check("step_from_notch_carry", int'(bus.carry_out), 1);
    tick();
    check("carry_one_cycle", int'(bus.carry_out), 0);
    check("pos_hold", int'(bus.position), 17);

    load_pos(25);
    bus.step_in = 1'b1;
    tick();
    bus.step_in = 1'b0;
    check("wrap_pos", int'(bus.position), 0);
    check("wrap_carry", int'(bus.carry_out), 0);

    load_pos(16);
    bus.step_in = 1'b1;
    load_pos(5);
    bus.step_in = 1'b0;
    check("load_beats_step_pos", int'(bus.position), 5);
    check("load_beats_step_carry", int'(bus.carry_out), 0);

    load_pos(27);
    check("pos_data_reduced", int'(bus.position), 1);

    // Same-cycle step uses the pre-step position.
    load_pos(0);
    bus.step_in = 1'b1;
    send(0, 1'b0, 4);
    bus.step_in = 1'b0;
    check("step_with_request_pos", int'(bus.position), 1);
    send(0, 1'b0, 9);

    // Reset the cycle after a request: the result already issued is seen,
    // then reset clears output, position and table.
    load_pos(7);
    send(0, 1'b0, 9);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_after_req_valid", int'(bus.out_valid), 0);
    check("rst_after_req_pos", int'(bus.position), 0);

    // Reset on the same edge as a request drops it entirely.
    load_pos(3);
    bus.in_valid = 1'b1;
    bus.in_data  = 5'd2;
    rst_n = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    check("rst_drop_valid", int'(bus.out_valid), 0);
    tick();
    check("rst_drop_valid_next", int'(bus.out_valid), 0);
    send(0, 1'b0, 0);
    send(5, 1'b0, 5);

    tick();
    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/enigma_rotor_stage.md
Name: enigma_rotor_stage

Overview:
Parametrised, clocked successor to the fixed-wiring combinational rotor.
- Holds a runtime-loadable wiring table and its inverse, a position register with stepping, and a ring setting.
- Produces a notch carry so stages can be cascaded into a rotor stack.
- Translation is a one-cycle registered valid-qualified path; the stack controller drives step and data requests.

Parameters:
N, 26, alphabet size (symbols 0..N-1)
W, 5, symbol width; must satisfy 2^W >= N
NOTCH, 16, position at which a step produces carry_out (16 = 'Q')

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
cfg_we  in  1  wiring table write strobe
cfg_addr  in  W  table index (contact in)
cfg_data  in  W  table value (contact out)
pos_we  in  1  load position register
pos_data  in  W  position value for pos_we
ring  in  W  ring setting (Ringstellung), static during traffic
step_in  in  1  advance position by one
in_valid  in  1  translation request
dir  in  1  0 = forward (entry to reflector), 1 = reverse
in_data  in  W  input symbol
out_valid  out  1  result valid
out_data  out  W  translated symbol
carry_out  out  1  one-cycle pulse when a step leaves NOTCH
position  out  W  current position register

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - position=0, out_valid=0, out_data=0, carry_out=0.
  - fwd[i]=i and inv[i]=i (identity) for all i.
  - Reset mid-translation drops the pending result; out_valid is 0 in the next cycle.
- Table write (cfg_we=1, cfg_addr<N, cfg_data<N):
  - fwd[cfg_addr]<=cfg_data and inv[cfg_data]<=cfg_addr in the same cycle.
  - Writes with an index >=N are ignored.
  - Software guarantees a permutation before use; non-permutation contents give undefined inv results, but no lockup.
- Translation:
  - Registered, latency 1: in_valid at edge k gives out_valid=1 with out_data during cycle k+1.
  - out_valid is 0 in cycles without a request. No backpressure.
  - Let s=(in_data+position-ring) mod N.
  - Forward: out=(fwd[s]-position+ring) mod N. Reverse: out=(inv[s]-position+ring) mod N.
  - All mod arithmetic is done at W+1 bits with conditional add/subtract of N; no % operator.
  - Translation uses the position and table values present before the edge. A same-cycle step, pos_we or cfg_we affects only later requests.
  - in_data>=N: out_data=in_data (pass-through), out_valid still asserted.
- Stepping:
  - step_in=1: position<=(position==N-1)?0:position+1.
  - carry_out<=1 for exactly one cycle iff the pre-step position==NOTCH; otherwise carry_out<=0.
- Priority:
  - pos_we beats step_in: position<=pos_data, with no carry.
  - pos_data>=N is reduced to pos_data-N.
- ring>=N is treated as ring-N.

Optional Feature:
- Macro: ROTOR_REV_PATH_EN.
- Defined: the inv table exists and dir selects the reverse path as above.
- Undefined:
  - The inv table is not built; cfg writes update fwd only.
  - dir is ignored; every request uses the forward path.
  - Saves N*W flops.

Test Plan:
- Reset, then in_valid, in_data=3, dir=0 -> next cycle out_valid=1, out_data=3 (identity). No output in idle cycles.
- Load wiring I (EKMFLGDQVZNTOWYHXUSPAIBRCJ = 4,10,12,5,11,6,3,16,21,25,13,19,14,22,24,7,23,20,18,15,0,8,1,17,2,9), pos=0, ring=0:
  - fwd in 0 -> 4; in 25 -> 9.
  - With ROTOR_REV_PATH_EN, rev in 4 -> 0, rev in 9 -> 25.
- Wiring I, pos_we with pos_data=1, ring=0, fwd in 0 -> 9. Then ring=1, pos=0, fwd in 0 -> 10.
- Stepping:
  - pos=16, step_in -> position=17, carry_out=1 for one cycle only.
  - pos=25, step_in -> position=0, carry_out=0.
  - pos_we(5) with step_in the same cycle -> position=5, carry_out=0.
- in_valid with step_in in the same cycle at pos=0, wiring I, in 0 -> result 4 (pre-step position); the following request at pos=1, in 0 -> 9.
- rst_n=0 asserted the cycle after in_valid -> out_valid=0, position=0, table back to identity (in 0 -> 0).
